adc_sample_scheduler: RTL and testbench
=======================================

# adc_sample_scheduler

Periodic conversion scheduler for the AD7324 SPI reader. It paces conversions by pulsing the reader's HOLD input from a programmable sample-period counter. It also selects single-channel or four-channel sequencer mode through READ_ALL. Each 16-bit result word is demultiplexed by its channel ID into per-channel sample registers with valid strobes, a frame-done pulse and sticky overrun/sequence-error flags. It sits between the SPI reader and the control-loop datapath of the power converter.

## Interface
- PERIOD, 100: cycles between conversion triggers; legal range 2..65535.
- HOLD_CYC, 2: HOLD high width in cycles; legal range 1..255.
- SETTLE, 20: cycles from HOLD fall to result capture; legal range 1..255. Covers the reader's 16-bit read and load.
- CLK_IN  in  1  system clock, same clock as the SPI reader.
- R  in  1  reset, asynchronous, active-low.
- EN  in  1  scheduler enable.
- ALL_CH  in  1  sequencer-mode request. Sampled only on the IDLE->WAIT transition.
- CLR  in  1  synchronous clear of OVERRUN and ERR.
- ADC_DATA  in  16  reader result word.
  - [14:13] channel ID.
  - [12:0] signed two's-complement result.
  - [15] ignored.
- HOLD  out  1  conversion gate to the reader; registered.
- READ_ALL  out  1  sequencer-mode select to the reader; registered.
- SAMPLES  out  52  per-channel results; channel n occupies [13n+12:13n].
- VALID  out  4  one-cycle strobe per channel, aligned with the SAMPLES update.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes.
- OVERRUN  out  1  sticky: a trigger arrived while a conversion was in flight.
- ERR  out  1  sticky: a received channel ID differed from the expected ID.

## Operation
- States: IDLE, WAIT, HOLD_HI, SETTLE, CAPTURE.
- Reset (R low, asynchronous) values:
  - State IDLE; HOLD, READ_ALL, VALID, FRAME_DONE, OVERRUN, ERR all 0.
  - SAMPLES all 0; period counter pcnt 0; wait counter wcnt 0; expected channel exp 0.
- IDLE:
  - HOLD=0, pcnt held at 0.
  - When EN=1: go to WAIT, set READ_ALL<=ALL_CH, set exp<=0.
- Period counter: pcnt runs in every non-IDLE state. Trigger = (pcnt==PERIOD-1); on a trigger pcnt wraps to 0.
- WAIT:
  - Trigger -> HOLD_HI with wcnt<=0.
  - EN=0 -> IDLE immediately.
- HOLD_HI: HOLD=1; after HOLD_CYC cycles -> SETTLE with wcnt<=0.
- SETTLE: HOLD=0; after SETTLE cycles -> CAPTURE.
- CAPTURE (one cycle):
  - id=ADC_DATA[14:13] is written into SAMPLES slot id; VALID[id] is set; both are registered and appear together on the exit edge.
  - If id!=exp, ERR<=1.
  - exp<=id+1 (2-bit wrap) when READ_ALL=1; exp stays 0 otherwise.
  - FRAME_DONE pulses when id==3 with READ_ALL=1, or on every capture with READ_ALL=0.
  - Next state is WAIT if EN=1, otherwise IDLE.
- Trigger in HOLD_HI, SETTLE or CAPTURE: the trigger is dropped, OVERRUN<=1, and pcnt still wraps.
- EN falling mid-conversion: the conversion completes and is captured, then the block goes to IDLE.
- CLR=1 clears OVERRUN and ERR. A set event in the same cycle wins.
- READ_ALL is fixed until the next IDLE->WAIT transition. The reader programs its mode only at its own reset, so a mode change requires R.
- Channel ID 1-3 received in single mode: sample stored, ERR set.

## Timing
- EN sampled at edge E0. The first trigger occurs at edge T=E0+PERIOD-1; later triggers at T+k*PERIOD.
- HOLD is high from edge T to edge T+HOLD_CYC.
- CAPTURE is entered at T+HOLD_CYC+SETTLE. SAMPLES/VALID/FRAME_DONE update at T+HOLD_CYC+SETTLE+1, i.e. trigger-to-data latency HOLD_CYC+SETTLE+1 (23 at defaults).
- Minimum PERIOD for overrun-free operation is HOLD_CYC+SETTLE+2.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Defaults, ALL_CH=0, EN=1 at E0, ADC_DATA=16'h0123:
  - HOLD high for edges E0+99..E0+101.
  - At E0+122, SAMPLES[12:0]=13'h0123 with VALID=4'b0001 and FRAME_DONE=1 for 1 cycle.
  - Repeats every 100 cycles; ERR stays 0.
- ALL_CH=1, ADC_DATA ID sequenced 0,1,2,3 with data 13'h1FFF/13'h0001/13'h1000/13'h0FFF:
  - VALID walks 0001,0010,0100,1000.
  - SAMPLES holds each value in its slot; READ_ALL=1.
  - FRAME_DONE only on the channel-3 capture.
- PERIOD=20 (below the 24 minimum):
  - OVERRUN=1 one edge after the 2nd trigger (T+20).
  - Conversions then occur every 40 cycles.
  - CLR pulse clears OVERRUN until the next dropped trigger.
- ALL_CH=1, IDs 0,2: ERR=1 after the second capture; exp resyncs to 3; CLR clears ERR.
- EN dropped during SETTLE: capture still occurs, then IDLE with HOLD=0 and no further triggers.
- EN dropped in WAIT: immediate IDLE, no capture.
- R asserted mid-HOLD_HI: HOLD and all outputs go to 0 asynchronously; after release, no HOLD until EN is seen plus PERIOD-1 cycles.

Source files
------------

// File: rtl/adc_sample_scheduler.sv
// ============================================================================
// Module   : adc_sample_scheduler
// Purpose  : Paces AD7324 conversions with a HOLD pulse and demultiplexes the
//            returned result words into per-channel sample registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_sample_scheduler #(
    parameter int PERIOD   = 100,
    parameter int HOLD_CYC = 2,
    parameter int SETTLE   = 20
) (
    input  logic        CLK_IN,
    input  logic        R,
    input  logic        EN,
    input  logic        ALL_CH,
    input  logic        CLR,
    input  logic [15:0] ADC_DATA,
    output logic        HOLD,
    output logic        READ_ALL,
    output logic [51:0] SAMPLES,
    output logic [3:0]  VALID,
    output logic        FRAME_DONE,
    output logic        OVERRUN,
    output logic        ERR
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);
    localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] pcnt;
    logic [7:0]  wcnt;
    logic [1:0]  exp_id;
    logic [1:0]  id;
    logic        trigger;
    logic        in_flight;
    logic        ovr_set;
    logic        err_set;
    logic        unused_msb;

    assign id         = ADC_DATA[14:13];
    assign unused_msb = ADC_DATA[15];
    assign trigger    = (state != ST_IDLE) && (pcnt == PERIOD_LAST);
    assign in_flight  = (state == ST_HOLD_HI) || (state == ST_SETTLE) ||
                        (state == ST_CAPTURE);
    assign ovr_set    = trigger && in_flight;
    assign err_set    = (state == ST_CAPTURE) && (id != exp_id);

    always_ff @(posedge CLK_IN or negedge R) begin
        if (!R) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (EN) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!EN)         next_state = ST_IDLE;
                else if (trigger) next_state = ST_HOLD_HI;
            end
            ST_HOLD_HI: begin
                if (wcnt == HOLD_LAST) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wcnt == SETTLE_LAST) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                next_state = EN ? ST_WAIT : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // pcnt is loaded with 1 on the enabling edge so the first trigger lands
    // PERIOD-1 edges after EN is seen.
    always_ff @(posedge CLK_IN or negedge R) begin
        if (!R) begin
            pcnt <= 16'd0;
            wcnt <= 8'd0;
        end else begin
            if (state == ST_IDLE) begin
                pcnt <= 16'(EN);
            end else if (trigger) begin
                pcnt <= 16'd0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            if (next_state != state) begin
                wcnt <= 8'd0;
            end else begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge R) begin
        if (!R) begin
            HOLD       <= 1'b0;
            READ_ALL   <= 1'b0;
            SAMPLES    <= 52'd0;
            VALID      <= 4'd0;
            FRAME_DONE <= 1'b0;
            OVERRUN    <= 1'b0;
            ERR        <= 1'b0;
            exp_id     <= 2'd0;
        end else begin
            HOLD       <= (next_state == ST_HOLD_HI);
            VALID      <= 4'd0;
            FRAME_DONE <= 1'b0;

            if ((state == ST_IDLE) && EN) begin
                READ_ALL <= ALL_CH;
                exp_id   <= 2'd0;
            end

            if (state == ST_CAPTURE) begin
                for (int n = 0; n < 4; n++) begin
                    if (id == 2'(n)) SAMPLES[13*n +: 13] <= ADC_DATA[12:0];
                end
                VALID      <= 4'b0001 << id;
                FRAME_DONE <= !READ_ALL || (id == 2'd3);
                exp_id     <= READ_ALL ? id + 2'd1 : 2'd0;
            end

            // A set event in the same cycle as CLR takes priority.
            if (ovr_set)  OVERRUN <= 1'b1;
            else if (CLR) OVERRUN <= 1'b0;

            if (err_set)  ERR <= 1'b1;
            else if (CLR) ERR <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
// ============================================================================
// Module   : tb_adc_sample_scheduler
// Purpose  : Directed self-checking bench with a capture scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc_sample_scheduler;

    logic        clk = 1'b0;
    logic        r, en, all_ch, clr, en2, clr2;
    logic [15:0] adc_data;

    logic        hold, read_all, frame_done, overrun, err;
    logic [51:0] samples;
    logic [3:0]  valid;
    logic        hold2, read_all2, frame_done2, overrun2, err2;
    logic [51:0] samples2;
    logic [3:0]  valid2;

    int cyc    = 0;
    int total  = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0]  valid;
        int          slot;
        logic [12:0] data;
        logic        frame;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    adc_sample_scheduler dut (
        .CLK_IN(clk), .R(r), .EN(en), .ALL_CH(all_ch), .CLR(clr),
        .ADC_DATA(adc_data), .HOLD(hold), .READ_ALL(read_all),
        .SAMPLES(samples), .VALID(valid), .FRAME_DONE(frame_done),
        .OVERRUN(overrun), .ERR(err)
    );

    adc_sample_scheduler #(.PERIOD(20), .HOLD_CYC(2), .SETTLE(20)) dut2 (
        .CLK_IN(clk), .R(r), .EN(en2), .ALL_CH(all_ch), .CLR(clr2),
        .ADC_DATA(adc_data), .HOLD(hold2), .READ_ALL(read_all2),
        .SAMPLES(samples2), .VALID(valid2), .FRAME_DONE(frame_done2),
        .OVERRUN(overrun2), .ERR(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input int slot, input logic [12:0] d, input logic fr, input int c);
        exp_t e;
        e.valid = 4'b0001 << slot;
        e.slot  = slot;
        e.data  = d;
        e.frame = fr;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Present a result word once the trigger has fired; its capture is due
    // HOLD_CYC+SETTLE+1 = 23 edges after the trigger.
    task automatic conv(input int t, input logic [1:0] id, input logic [12:0] d, input logic fr);
        wait_cyc(t);
        adc_data = {1'b0, id, d};
        push(int'(id), d, fr, t + 23);
    endtask

    always @(negedge clk) begin
        if (valid !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid", 64'(valid), 64'(e.valid));
                chk("slot_data", 64'(samples[13*e.slot +: 13]), 64'(e.data));
                chk("frame_done", 64'(frame_done), 64'(e.frame));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e1, e2, e3, e4, t, t1;
        logic [12:0] dv [7];
        logic [1:0]  iv [7];
        dv = '{13'h1FFF, 13'h0001, 13'h1000, 13'h0FFF, 13'h0AAA, 13'h0555, 13'h0777};
        iv = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

        r = 1'b0; en = 1'b0; all_ch = 1'b0; clr = 1'b0;
        en2 = 1'b0; clr2 = 1'b0; adc_data = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_hold", 64'(hold), 64'd0);
        chk("rst_flags", 64'({read_all, valid, frame_done, overrun, err}), 64'd0);
        chk("rst_samples", 64'(samples), 64'd0);
        r = 1'b1;
        @(negedge clk);

        // Single-channel mode at default timing.
        adc_data = 16'h0123;
        en = 1'b1;
        e0 = cyc + 1;
        push(0, 13'h0123, 1'b1, e0 + 122);
        push(0, 13'h0123, 1'b1, e0 + 222);
        wait_cyc(e0 + 98);  chk("hold_before_trig", 64'(hold), 64'd0);
        wait_cyc(e0 + 99);  chk("hold_rise", 64'(hold), 64'd1);
        wait_cyc(e0 + 100); chk("hold_high2", 64'(hold), 64'd1);
        wait_cyc(e0 + 101); chk("hold_fall", 64'(hold), 64'd0);
        wait_cyc(e0 + 225);
        chk("single_err", 64'(err), 64'd0);
        chk("single_read_all", 64'(read_all), 64'd0);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // EN dropped while waiting: no further trigger or capture.
        en = 1'b0;
        wait_cyc(e0 + 300); chk("wait_drop_hold", 64'(hold), 64'd0);
        wait_cyc(e0 + 330); chk("wait_drop_no_capture", 64'(sb.size()), 64'd0);

        // Four-channel sequencer mode.
        all_ch = 1'b1;
        en = 1'b1;
        e1 = cyc + 1;
        for (int k = 0; k < 4; k++) conv(e1 + 99 + 100*k, iv[k], dv[k], iv[k] == 2'd3);
        wait_cyc(e1 + 99 + 300 + 24);
        chk("seq_read_all", 64'(read_all), 64'd1);
        chk("seq_err", 64'(err), 64'd0);
        chk("seq_samples", 64'(samples), 64'({13'h0FFF, 13'h1000, 13'h0001, 13'h1FFF}));

        // Skipped channel ID: ERR set, then resync to the following ID.
        conv(e1 + 499, iv[4], dv[4], 1'b0);
        conv(e1 + 599, iv[5], dv[5], 1'b0);
        wait_cyc(e1 + 623); chk("seq_err_set", 64'(err), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("seq_err_clr", 64'(err), 64'd0);
        conv(e1 + 699, iv[6], dv[6], 1'b1);
        wait_cyc(e1 + 723); chk("seq_resync_no_err", 64'(err), 64'd0);

        // EN dropped mid-settle: the conversion still completes.
        t = e1 + 799;
        conv(t, 2'd0, 13'h0321, 1'b0);
        wait_cyc(t + 10);  en = 1'b0;
        wait_cyc(t + 101); chk("settle_drop_no_trig", 64'(hold), 64'd0);
        wait_cyc(t + 125); chk("settle_drop_sb_empty", 64'(sb.size()), 64'd0);

        // Second instance with PERIOD=20, below the overrun-free minimum.
        all_ch = 1'b0;
        adc_data = 16'h0042;
        en2 = 1'b1;
        e2 = cyc + 1;
        t1 = e2 + 19;
        wait_cyc(t1);      chk("ovr_hold_rise", 64'(hold2), 64'd1);
        wait_cyc(t1 + 19); chk("ovr_before", 64'(overrun2), 64'd0);
        wait_cyc(t1 + 20);
        chk("ovr_set", 64'(overrun2), 64'd1);
        chk("ovr_dropped_hold", 64'(hold2), 64'd0);
        wait_cyc(t1 + 23);
        chk("ovr_valid", 64'(valid2), 64'd1);
        chk("ovr_sample", 64'(samples2[12:0]), 64'h42);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        chk("ovr_clr", 64'(overrun2), 64'd0);
        wait_cyc(t1 + 40); chk("ovr_next_conv", 64'(hold2), 64'd1);
        wait_cyc(t1 + 59); chk("ovr_still_clear", 64'(overrun2), 64'd0);
        wait_cyc(t1 + 60); chk("ovr_reset_again", 64'(overrun2), 64'd1);
        en2 = 1'b0;

        // Asynchronous reset in the middle of HOLD high.
        en = 1'b1;
        e3 = cyc + 1;
        wait_cyc(e3 + 99); chk("pre_rst_hold", 64'(hold), 64'd1);
        #1 r = 1'b0;
        #1;
        chk("async_rst_hold", 64'(hold), 64'd0);
        chk("async_rst_samples", 64'(samples), 64'd0);
        chk("async_rst_ovr2", 64'(overrun2), 64'd0);
        @(negedge clk);
        r = 1'b1;
        e4 = cyc + 1;
        wait_cyc(e4 + 98); chk("post_rst_no_hold", 64'(hold), 64'd0);
        wait_cyc(e4 + 99); chk("post_rst_hold", 64'(hold), 64'd1);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

`default_nettype wire
